// File: rtl/foo_sched_pkg.sv
// Shared types and defaults for the foo_sched round-robin scheduler.
package foo_sched_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} foo_sched_state_t;

    // Default key width; matches the 4-bit rolling counter of the match resource.
    localparam int unsigned KEY_W_DEF = 4;

endpackage

// File: rtl/foo_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr_i, wrapping.
module rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_vld_o
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned     off);
        return IDX_W'((32'(base) + off) % N_REQ);
    endfunction

    // Scan upward from the pointer; the first hit wins.
    always_comb begin
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            if (!grant_vld_o && req_i[wrap_idx(rr_ptr_i, off)]) begin
                grant_idx_o = wrap_idx(rr_ptr_i, off);
                grant_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/foo_sched.sv
// Round-robin scheduler sharing one rolling-key match resource between N_REQ clients.
// Optional macro FOO_SCHED_TIMEOUT_EN: abort a BUSY transaction after TIMEOUT cycles
// and flag the completion with err_o.
module foo_sched
    import foo_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned KEY_W   = KEY_W_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*KEY_W-1:0] key_i,
    output logic [N_REQ-1:0]       done_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic                   foo_req,
    output logic [KEY_W-1:0]       foo_key,
    input  logic                   foo_ack,
    output logic [KEY_W+1:0]       last_wait_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = KEY_W + 2;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("foo_sched: N_REQ must be in 2..8");
    end
    if (TIMEOUT < (1 << KEY_W)) begin : g_bad_timeout
        $error("foo_sched: TIMEOUT must cover a full key rotation");
    end

    foo_sched_state_t state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] last_wait_q, last_wait_d;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_vld;
`ifdef FOO_SCHED_TIMEOUT_EN
    logic             err_q, err_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i       (req_i),
        .rr_ptr_i    (rr_ptr_q),
        .grant_idx_o (arb_idx),
        .grant_vld_o (arb_vld)
    );

    // Next-state and outputs; all outputs decode from registered state.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        key_d       = key_q;
        wait_cnt_d  = wait_cnt_q;
        last_wait_d = last_wait_q;
`ifdef FOO_SCHED_TIMEOUT_EN
        err_d       = err_q;
`endif
        done_o      = '0;
        busy_o      = 1'b0;
        foo_req     = 1'b0;
        foo_key     = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    grant_idx_d = arb_idx;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (arb_idx == IDX_W'(i)) key_d = key_i[i*KEY_W +: KEY_W];
                    end
                    wait_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                busy_o  = 1'b1;
                foo_req = 1'b1;
                foo_key = key_q;
                // wait_cnt holds completed BUSY cycles; the exit cycle is added in DONE.
                if (foo_ack) begin
                    state_d = DONE;
`ifdef FOO_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
`endif
                end else begin
                    wait_cnt_d = sat_inc(wait_cnt_q);
                end
            end
            DONE: begin
                busy_o              = 1'b1;
                done_o[grant_idx_q] = 1'b1;
                last_wait_d         = sat_inc(wait_cnt_q);
                rr_ptr_d            = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0
                                                                         : grant_idx_q + 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FOO_SCHED_TIMEOUT_EN
    assign err_o = (state_q == DONE) && err_q;
`else
    assign err_o = 1'b0;
`endif

    assign last_wait_o = last_wait_q;

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            key_q       <= '0;
            wait_cnt_q  <= '0;
            last_wait_q <= '0;
`ifdef FOO_SCHED_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            key_q       <= key_d;
            wait_cnt_q  <= wait_cnt_d;
            last_wait_q <= last_wait_d;
`ifdef FOO_SCHED_TIMEOUT_EN
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_foo_sched.sv
// Directed bench for foo_sched with a scoreboard of expected completions.
module tb_foo_sched;

    localparam int N_REQ   = 4;
    localparam int KEY_W   = 4;
    localparam int TIMEOUT = 16;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_i;
    logic [N_REQ*KEY_W-1:0] key_i;
    logic [N_REQ-1:0]       done_o;
    logic                   err_o;
    logic                   busy_o;
    logic                   foo_req;
    logic [KEY_W-1:0]       foo_key;
    logic                   foo_ack;
    logic [KEY_W+1:0]       last_wait_o;

    typedef struct {
        int         idx;
        logic [5:0] wt;
        logic       err;
        logic [3:0] key;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Ack model: acks in BUSY cycle ack_at (1-based); 0 means never, ack_now forces it.
    int busy_cyc = 0;
    int ack_at   = 0;
    bit ack_now  = 0;

    bit         done_seen = 0;
    bit         lw_pend   = 0;
    logic [5:0] lw_exp    = '0;

    foo_sched #(
        .N_REQ   (N_REQ),
        .KEY_W   (KEY_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .key_i       (key_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .foo_req     (foo_req),
        .foo_key     (foo_key),
        .foo_ack     (foo_ack),
        .last_wait_o (last_wait_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) busy_cyc <= foo_req ? busy_cyc + 1 : 0;

    assign foo_ack = foo_req && (ack_now || (ack_at != 0 && busy_cyc == ack_at - 1));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_key(input int slot, input logic [3:0] k);
        key_i[slot*KEY_W +: KEY_W] = k;
    endtask

    task automatic push(input int idx, input int wt, input logic err, input logic [3:0] key);
        exp_t e;
        e.idx = idx;
        e.wt  = 6'(wt);
        e.err = err;
        e.key = key;
        sb.push_back(e);
    endtask

    // One clock; sample 1 unit after the edge and score whatever the DUT shows.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (lw_pend) begin
            chk("last_wait", 32'(last_wait_o), 32'(lw_exp));
            lw_pend = 0;
        end
        if (foo_req && sb.size() > 0) chk("foo_key", 32'(foo_key), 32'(sb[0].key));
        done_seen = (done_o != '0);
        if (done_seen) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 32'(done_o), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("done_onehot", 32'(done_o), 32'(1) << e.idx);
                chk("err", 32'(err_o), 32'(e.err));
                lw_exp  = e.wt;
                lw_pend = 1;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done_seen && n < max);
        chk({tag, "_seen"}, 32'(done_seen), 32'h1);
    endtask

    initial begin
        int n;
        rst   = 1'b0;
        req_i = '0;
        key_i = '0;
        #1;
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_foo_req", 32'(foo_req), 32'h0);
        chk("rst_foo_key", 32'(foo_key), 32'h0);
        chk("rst_last_wait", 32'(last_wait_o), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();

        // Single requester, ack in BUSY cycle 4.
        ack_at = 4;
        set_key(0, 4'hC);
        req_i = 4'b0001;
        push(0, 4, 1'b0, 4'hC);
        wait_done("single", 30, n);
        chk("single_latency", 32'(n), 32'd5);
        req_i = '0;
        tick();
        tick();
        chk("single_idle", 32'(busy_o), 32'h0);

        // Round robin from rr_ptr=0 with all requesters held high.
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        ack_at = 1;
        for (int i = 0; i < N_REQ; i++) set_key(i, 4'(i + 1));
        @(posedge clk);
        #1;
        req_i = 4'b1111;
        push(0, 1, 1'b0, 4'h1);
        push(1, 1, 1'b0, 4'h2);
        push(2, 1, 1'b0, 4'h3);
        push(3, 1, 1'b0, 4'h4);
        push(0, 1, 1'b0, 4'h1);
        wait_done("rr0", 10, n);
        chk("rr0_latency", 32'(n), 32'd2);
        for (int k = 1; k < 5; k++) begin
            wait_done("rr", 10, n);
            chk("rr_spacing", 32'(n), 32'd3);
        end
        req_i = '0;
        tick();
        tick();

        // Key changes mid-BUSY are ignored.
        ack_at = 3;
        set_key(0, 4'h5);
        req_i = 4'b0001;
        push(0, 3, 1'b0, 4'h5);
        tick();
        set_key(0, 4'h9);
        wait_done("keychg", 30, n);
        chk("keychg_latency", 32'(n), 32'd3);
        req_i = '0;
        tick();
        tick();

        // Reset mid-BUSY: outputs drop with no clock edge, no completion afterwards.
        ack_at = 0;
        set_key(1, 4'h7);
        req_i = 4'b0010;
        tick();
        tick();
        chk("pre_rst_busy", 32'(busy_o), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 32'h0);
        chk("mid_rst_foo_req", 32'(foo_req), 32'h0);
        chk("mid_rst_foo_key", 32'(foo_key), 32'h0);
        chk("mid_rst_done", 32'(done_o), 32'h0);
        chk("mid_rst_last_wait", 32'(last_wait_o), 32'h0);
        req_i = '0;
        @(negedge clk) rst = 1'b1;
        repeat (5) tick();
        // rr_ptr back at 0: requester 0 must win over requester 1.
        ack_at = 1;
        set_key(0, 4'hA);
        set_key(1, 4'hB);
        req_i = 4'b0011;
        push(0, 1, 1'b0, 4'hA);
        push(1, 1, 1'b0, 4'hB);
        wait_done("ptr0_a", 10, n);
        req_i = 4'b0010;
        wait_done("ptr0_b", 10, n);
        req_i = '0;
        tick();
        tick();

        // Resource never acks.
        ack_at = 0;
        set_key(0, 4'h2);
        req_i = 4'b0001;
`ifdef FOO_SCHED_TIMEOUT_EN
        push(0, TIMEOUT, 1'b1, 4'h2);
        wait_done("timeout", 40, n);
        chk("timeout_latency", 32'(n), 32'(TIMEOUT + 1));
        req_i = '0;
        tick();
        tick();
`else
        push(0, 63, 1'b0, 4'h2);
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("noack_busy", 32'(busy_o), 32'h1);
            chk("noack_err", 32'(err_o), 32'h0);
        end
        ack_now = 1;
        wait_done("noack_release", 5, n);
        ack_now = 0;
        req_i = '0;
        tick();
        tick();

        // Saturation: 64 BUSY cycles just overflows the 6-bit count; 71 is well past it.
        ack_at = 64;
        set_key(2, 4'h6);
        req_i = 4'b0100;
        push(2, 63, 1'b0, 4'h6);
        wait_done("sat64", 100, n);
        chk("sat64_latency", 32'(n), 32'd65);
        req_i = '0;
        tick();
        tick();

        ack_at = 71;
        set_key(3, 4'h3);
        req_i = 4'b1000;
        push(3, 63, 1'b0, 4'h3);
        wait_done("sat71", 100, n);
        chk("sat71_latency", 32'(n), 32'd72);
        req_i = '0;
        tick();
        tick();
`endif

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
